synth_ctrl_regbank: RTL

//  Avalon-MM slave register bank for the synth core, parametrised in voice count.

---
 rtl/synth_ctrl_pkg.sv | 51 +++++
 rtl/synth_ctrl_regbank_if.sv | 21 ++
 rtl/key_event_fifo.sv | 62 ++++++
 rtl/synth_ctrl_regbank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/synth_ctrl_pkg.sv
// Shared definitions for the synth control register bank: register map, note-event
// layout, status word bit positions and the byte-lane merge helper.
package synth_ctrl_pkg;

  localparam int ADDR_SHAPE1     = 0;
  localparam int ADDR_SHAPE0     = 1;
  localparam int ADDR_ATTACK     = 2;
  localparam int ADDR_DECAY      = 3;
  localparam int ADDR_SUSTAIN    = 4;
  localparam int ADDR_RLEASE     = 5;
  localparam int ADDR_GLIDE_EN   = 6;
  localparam int ADDR_GLIDE_RATE = 7;
  localparam int ADDR_ARP_EN     = 8;
  localparam int ADDR_ARP_TIME   = 9;
  localparam int ADDR_STATUS     = 10;
  localparam int NUM_GLOB        = 10;

  localparam int KEY_BASE  = 32;
  localparam int FREQ_BASE = 40;
  localparam int AMP1_BASE = 48;
  localparam int AMP0_BASE = 56;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 16;

  typedef enum logic [1:0] {
    GRP_KEY  = 2'd0,
    GRP_FREQ = 2'd1,
    GRP_AMP1 = 2'd2,
    GRP_AMP0 = 2'd3
  } voice_grp_e;

  typedef struct packed {
    logic       on;
    logic [2:0] voice;
  } evt_t;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/synth_ctrl_regbank_if.sv
// Avalon-MM slave bus bundle for the synth control register bank.
interface synth_ctrl_regbank_if;
  logic [5:0]  AVL_ADDR;
  logic [3:0]  AVL_BYTE_EN;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        AVL_READDATAVALID;

  modport master (
    output AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    input  AVL_READDATA, AVL_READDATAVALID
  );

  modport slave (
    input  AVL_ADDR, AVL_BYTE_EN, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    output AVL_READDATA, AVL_READDATAVALID
  );
endinterface

// File: rtl/key_event_fifo.sv
// Synchronous FIFO for note events; head word is presented combinationally so an
// event is visible the cycle after it is pushed.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o    = (level_q == '0);
  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/synth_ctrl_regbank.sv
// Avalon-MM register bank for the synth core: global patch params, per-voice regs,
// registered reads, and key-bit edge detection feeding a note-event FIFO.
module synth_ctrl_regbank
  import synth_ctrl_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int EVT_DEPTH  = 8
) (
  input  logic                      CLK,
  input  logic                      RESET,
  synth_ctrl_regbank_if.slave       bus,
  output logic [1:0]                SHAPE1,
  output logic [1:0]                SHAPE0,
  output logic [15:0]               ATTACK,
  output logic [15:0]               DECAY,
  output logic [15:0]               SUSTAIN,
  output logic [15:0]               RLEASE,
  output logic                      GLIDE_EN,
  output logic [24:0]               GLIDE_RATE,
  output logic                      ARP_EN,
  output logic [15:0]               ARP_TIME,
  output logic [NUM_VOICES-1:0]     KEY,
  output logic [7*NUM_VOICES-1:0]   FREQ,
  output logic [16*NUM_VOICES-1:0]  AMP1,
  output logic [16*NUM_VOICES-1:0]  AMP0,
  output logic                      EVT_VALID,
  output logic [3:0]                EVT_DATA,
  input  logic                      EVT_READY
);

  logic [31:0] glob_q [NUM_GLOB];
  logic [31:0] key_q  [NUM_VOICES];
  logic [31:0] freq_q [NUM_VOICES];
  logic [31:0] amp1_q [NUM_VOICES];
  logic [31:0] amp0_q [NUM_VOICES];

  logic                     wr_en;
  logic                     rd_en;
  logic [5:0]               addr;
  logic [3:0]               be;
  logic [31:0]              wdata;
  logic [2:0]               voice;
  voice_grp_e               grp;
  logic                     voice_hit;
  logic [7:0]               key_pad;
  logic                     key_push;
  evt_t                     push_evt;
  evt_t                     head_evt;
  logic                     evt_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(EVT_DEPTH):0] fifo_level;
  logic                     ovf_q;
  logic                     ovf_d;
  logic                     rdv_q;
  logic [31:0]              rdata_q;
  logic [31:0]              rdata_d;
  logic [31:0]              status_word;

  assign addr  = bus.AVL_ADDR;
  assign be    = bus.AVL_BYTE_EN;
  assign wdata = bus.AVL_WRITEDATA;
  assign voice = addr[2:0];
  assign wr_en = bus.AVL_WRITE & bus.AVL_CS;
  // A simultaneous write wins; the read is dropped entirely.
  assign rd_en = bus.AVL_READ & bus.AVL_CS & ~bus.AVL_WRITE;

  always_comb begin
    grp       = GRP_KEY;
    voice_hit = 1'b0;
    if (addr[5] && (int'(voice) < NUM_VOICES)) begin
      voice_hit = 1'b1;
      case (int'(addr[5:3]))
        KEY_BASE / 8:  grp = GRP_KEY;
        FREQ_BASE / 8: grp = GRP_FREQ;
        AMP1_BASE / 8: grp = GRP_AMP1;
        AMP0_BASE / 8: grp = GRP_AMP0;
        default:       voice_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_GLOB; i++) glob_q[i] <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v]  <= '0;
        freq_q[v] <= '0;
        amp1_q[v] <= '0;
        amp0_q[v] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < NUM_GLOB; i++) begin
        if (addr == 6'(i)) glob_q[i] <= merge_lanes(glob_q[i], wdata, be);
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_hit && (voice == 3'(v))) begin
          case (grp)
            GRP_KEY:  key_q[v]  <= merge_lanes(key_q[v],  wdata, be);
            GRP_FREQ: freq_q[v] <= merge_lanes(freq_q[v], wdata, be);
            GRP_AMP1: amp1_q[v] <= merge_lanes(amp1_q[v], wdata, be);
            GRP_AMP0: amp0_q[v] <= merge_lanes(amp0_q[v], wdata, be);
          endcase
        end
      end
    end
  end

  assign SHAPE1     = glob_q[ADDR_SHAPE1][1:0];
  assign SHAPE0     = glob_q[ADDR_SHAPE0][1:0];
  assign ATTACK     = glob_q[ADDR_ATTACK][15:0];
  assign DECAY      = glob_q[ADDR_DECAY][15:0];
  assign SUSTAIN    = glob_q[ADDR_SUSTAIN][15:0];
  assign RLEASE     = glob_q[ADDR_RLEASE][15:0];
  assign GLIDE_EN   = glob_q[ADDR_GLIDE_EN][0];
  assign GLIDE_RATE = glob_q[ADDR_GLIDE_RATE][24:0];
  assign ARP_EN     = glob_q[ADDR_ARP_EN][0];
  assign ARP_TIME   = glob_q[ADDR_ARP_TIME][15:0];

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign KEY[gi]          = key_q[gi][0];
      assign FREQ[7*gi +: 7]  = freq_q[gi][6:0];
      assign AMP1[16*gi +: 16] = amp1_q[gi][15:0];
      assign AMP0[16*gi +: 16] = amp0_q[gi][15:0];
    end
  endgenerate

  // Padded to the full 3-bit voice range so the edge check can index by address.
  assign key_pad = 8'(KEY);

  always_comb begin
    key_push = wr_en && voice_hit && (grp == GRP_KEY) && be[0] &&
               (wdata[0] != key_pad[voice]);
    push_evt = '{on: wdata[0], voice: voice};
  end

  assign evt_pop   = EVT_VALID & EVT_READY;
  assign EVT_VALID = ~fifo_empty;
  assign EVT_DATA  = head_evt;

  key_event_fifo #(
    .DEPTH (EVT_DEPTH),
    .WIDTH (4)
  ) u_evt_fifo (
    .CLK         (CLK),
    .RESET       (RESET),
    .push_i      (key_push),
    .push_data_i (push_evt),
    .pop_i       (evt_pop),
    .pop_data_o  (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (key_push && fifo_full && !evt_pop) begin
      ovf_d = 1'b1;
    end else if (wr_en && (addr == 6'(ADDR_STATUS)) && be[2] && wdata[STAT_OVF_BIT]) begin
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    status_word                        = '0;
    status_word[STAT_LEVEL_LSB +: 8]   = 8'(fifo_level);
    status_word[STAT_EMPTY_BIT]        = fifo_empty;
    status_word[STAT_FULL_BIT]         = fifo_full;
    status_word[STAT_OVF_BIT]          = ovf_q;
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_GLOB; i++) begin
      if (addr == 6'(i)) rdata_d = glob_q[i];
    end
    if (addr == 6'(ADDR_STATUS)) rdata_d = status_word;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (voice_hit && (voice == 3'(v))) begin
        case (grp)
          GRP_KEY:  rdata_d = key_q[v];
          GRP_FREQ: rdata_d = freq_q[v];
          GRP_AMP1: rdata_d = amp1_q[v];
          GRP_AMP0: rdata_d = amp0_q[v];
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rdv_q <= rd_en;
      if (rd_en) rdata_q <= rdata_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.AVL_READDATA      = rdata_q;
  assign bus.AVL_READDATAVALID = rdv_q;

endmodule
